// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and zeroed control on bubbles.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_nx;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nx;
  logic [DATA_W-1:0] main_data, main_data_nx;
  logic [DATA_W-1:0] skid_data, skid_data_nx;
  logic              ready_q, ready_nx;
  logic              in_fire, out_fire;

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Without a skid entry the stage can only take a beat when the head leaves
  // in the same cycle, so ready has to see out_ready combinationally.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = ready_q;
    end else begin : g_flow_ready
      assign in_ready = ready_q & (~out_valid | out_ready);
    end
  endgenerate

  // Next-state, next-entry and next-ready computation
  always_comb begin
    state_nx     = state;
    main_ctrl_nx = main_ctrl;
    main_data_nx = main_data;
    skid_ctrl_nx = skid_ctrl;
    skid_data_nx = skid_data;
    if (flush) begin
      // Payload is deliberately kept; only control is cleared.
      state_nx     = EMPTY;
      main_ctrl_nx = '0;
      skid_ctrl_nx = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nx     = ONE;
            main_ctrl_nx = in_ctrl;
            main_data_nx = in_data;
          end else begin
            state_nx = EMPTY;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            state_nx     = ONE;
            main_ctrl_nx = in_ctrl;
            main_data_nx = in_data;
          end else if (in_fire && (SKID != 0)) begin
            state_nx     = FULL;
            skid_ctrl_nx = in_ctrl;
            skid_data_nx = in_data;
          end else if (out_fire) begin
            state_nx     = EMPTY;
            main_ctrl_nx = '0;
          end else begin
            state_nx = ONE;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nx     = ONE;
            main_ctrl_nx = skid_ctrl;
            main_data_nx = skid_data;
            skid_ctrl_nx = '0;
          end else begin
            state_nx = FULL;
          end
        end
        default: begin
          state_nx     = EMPTY;
          main_ctrl_nx = '0;
          skid_ctrl_nx = '0;
        end
      endcase
    end
    if (SKID != 0) begin
      ready_nx = (state_nx != FULL);
    end else begin
      ready_nx = 1'b1;
    end
  end

  // State and entry registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      main_ctrl <= main_ctrl_nx;
      main_data <= main_data_nx;
      skid_ctrl <= skid_ctrl_nx;
      skid_data <= skid_data_nx;
      ready_q   <= ready_nx;
    end
  end

  // Head outputs; control is masked so a bubble never carries stale bits
  always_comb begin
    out_data = main_data;
    if (out_valid) begin
      out_ctrl = main_ctrl;
    end else begin
      out_ctrl = '0;
    end
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: two builds (SKID=1, SKID=0) share stimulus; each has its own
// expected-beat queue modelling the stage as an ordered FIFO of capacity 2 or 1.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 9;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready_a, out_valid_a;
  logic [CW-1:0] out_ctrl_a;
  logic [DW-1:0] out_data_a;
  logic [1:0]    occ_a;
  logic          in_ready_b, out_valid_b;
  logic [CW-1:0] out_ctrl_b;
  logic [DW-1:0] out_data_b;
  logic [1:0]    occ_b;

  int            n_tests;
  int            n_fail;
  logic          last_rst;
  logic [DW-1:0] data_cnt;
  logic [CW+DW-1:0] sb_q [2][$];

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a),
    .out_data(out_data_a), .occupancy(occ_a)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_flow (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
    .out_data(out_data_b), .occupancy(occ_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Compare one DUT against its queue, then advance the queue for the coming edge.
  task automatic eval(input int k, input logic ir, input logic ov, input logic [CW-1:0] oc,
                      input logic [DW-1:0] od, input logic [1:0] oo);
    int sz;
    logic exp_ready;
    if (!last_rst) begin
      check("rst_out_valid", k, {63'd0, ov}, 64'd0);
      check("rst_out_ctrl", k, {55'd0, oc}, 64'd0);
      check("rst_out_data", k, {32'd0, od}, 64'd0);
      check("rst_occupancy", k, {62'd0, oo}, 64'd0);
      check("rst_in_ready", k, {63'd0, ir}, 64'd0);
    end else begin
      sz = sb_q[k].size();
      if (k == 0) exp_ready = (sz < 2);
      else        exp_ready = (sz == 0) || out_ready;
      check("occupancy", k, {62'd0, oo}, 64'(sz));
      check("out_valid", k, {63'd0, ov}, {63'd0, (sz != 0)});
      check("in_ready", k, {63'd0, ir}, {63'd0, exp_ready});
      if (ov && sz != 0) begin
        check("head_beat", k, {23'd0, oc, od}, {23'd0, sb_q[k][0]});
      end else if (!ov) begin
        check("bubble_ctrl", k, {55'd0, oc}, 64'd0);
      end
    end
    if (!rst) begin
      sb_q[k].delete();
    end else begin
      if (ov && out_ready && sb_q[k].size() != 0) void'(sb_q[k].pop_front());
      if (flush) sb_q[k].delete();
      else if (in_valid && ir) sb_q[k].push_back({in_ctrl, in_data});
    end
  endtask

  always @(negedge clk) begin
    eval(0, in_ready_a, out_valid_a, out_ctrl_a, out_data_a, occ_a);
    eval(1, in_ready_b, out_valid_b, out_ctrl_b, out_data_b, occ_b);
    last_rst = rst;
  end

  task automatic drive(input logic v, input logic ordy, input logic fl, input logic r,
                       input logic [CW-1:0] c);
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    in_ctrl   = c;
    in_data   = data_cnt;
    data_cnt  = data_cnt + 32'd1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    last_rst  = 1'b0;
    data_cnt  = 32'd1;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    in_data   = 32'd0;

    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
    // stream of 8 beats
    data_cnt = 32'd1;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 9'(i + 1));
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h000);
    // backpressure for 4 cycles starting at beat 3
    for (int i = 0; i < 12; i++)
      drive(1'b1, !(i >= 3 && i < 7), 1'b0, 1'b1, 9'(8'h40 + i));
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h000);
    // fill, then flush with an input beat offered
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1, 9'h0A5);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 9'h15A);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h000);
    // bubble mid-stream with all control bits set
    drive(1'b1, 1'b1, 1'b0, 1'b1, 9'h1FF);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 9'h1FF);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h1FF);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 9'h1FF);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h1FF);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h000);
    // reset while full
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1, 9'h033);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 9'h033);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h000);
    // out_ready toggling
    for (int i = 0; i < 12; i++) drive(1'b1, (i % 2) == 0, 1'b0, 1'b1, 9'(i));
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h000);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0,
            ($urandom % 200) != 0, 9'($urandom));
    repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b1, 9'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
